// File: rtl/cnn_frame_seq_pkg.sv
// Shared encodings and defaults for the CNN frame sequencer and its helpers.
package cnn_frame_seq_pkg;

  localparam int DEF_ALPHA_W   = 8;
  localparam int DEF_FRAME_PIX = 784;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_STREAM   = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_HOLD     = 3'd4
  } seq_state_e;

  // Counter width that stays >= 1 bit for degenerate parameter values.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_frame_seq_timeout_cnt.sv
// Saturating wait-cycle counter: clears on clr, counts while en, flags the last allowed cycle.
module seq_timeout_cnt
  import cnn_frame_seq_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            CW   = cnt_w(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en && (cnt != LAST)) cnt <= cnt + 1'b1;
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/cnn_frame_seq.sv
// Gates exactly one camera frame into the CNN per host request and holds the result until acked.
module cnn_frame_seq
  import cnn_frame_seq_pkg::*;
#(
  parameter int PIX_W       = 32,
  parameter int ALPHA_W     = DEF_ALPHA_W,
  parameter int FRAME_PIX   = DEF_FRAME_PIX,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_start,
  input  logic               host_ack,
  input  logic               pix_sof,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  output logic               cnn_valid,
  output logic [PIX_W-1:0]   cnn_pixel,
  input  logic               cnn_done,
  input  logic [ALPHA_W-1:0] cnn_alpha,
  output logic               res_valid,
  output logic [ALPHA_W-1:0] res_alpha,
  output logic               busy,
  output logic               err_timeout
);

  localparam int            PW       = cnt_w(FRAME_PIX + 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(FRAME_PIX - 1);

  seq_state_e    state;
  logic [PW-1:0] pix_cnt;
  logic          tmo_expire;
  logic          sof_hit;

  assign sof_hit = pix_valid && pix_sof;

  seq_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (state != ST_WAIT_RES),
    .en     (state == ST_WAIT_RES),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pix_cnt     <= '0;
      cnn_valid   <= 1'b0;
      cnn_pixel   <= '0;
      res_valid   <= 1'b0;
      res_alpha   <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cnn_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host_start) begin
            state       <= ST_WAIT_SOF;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
          end
        end
        ST_WAIT_SOF: begin
          if (sof_hit) begin
            cnn_valid <= 1'b1;
            cnn_pixel <= pix_data;
            if (FRAME_PIX == 1) begin
              state   <= ST_WAIT_RES;
              pix_cnt <= '0;
            end else begin
              state   <= ST_STREAM;
              pix_cnt <= PW'(1);
            end
          end
        end
        ST_STREAM: begin
          if (pix_valid) begin
            // A mid-frame SOF re-anchors the count; the pixel itself is withheld.
            if (pix_sof) begin
              pix_cnt <= PW'(1);
            end else begin
              cnn_valid <= 1'b1;
              cnn_pixel <= pix_data;
              if (pix_cnt == LAST_PIX) begin
                state   <= ST_WAIT_RES;
                pix_cnt <= '0;
              end else begin
                pix_cnt <= pix_cnt + 1'b1;
              end
            end
          end
        end
        ST_WAIT_RES: begin
          if (cnn_done) begin
            res_alpha <= cnn_alpha;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end else if (tmo_expire) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (host_ack) begin
            res_valid <= 1'b0;
            if (host_start) begin
              state <= ST_WAIT_SOF;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_frame_seq.sv
// Directed bench for cnn_frame_seq with a 4-pixel frame and 16-cycle result timeout.
module tb_cnn_frame_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_start, host_ack, pix_sof, pix_valid, cnn_done;
  logic [31:0] pix_data;
  logic [7:0]  cnn_alpha;
  logic        cnn_valid, res_valid, busy, err_timeout;
  logic [31:0] cnn_pixel;
  logic [7:0]  res_alpha;

  int checks   = 0;
  int failures = 0;
  logic [31:0] fwd_q[$];

  cnn_frame_seq #(.PIX_W(32), .ALPHA_W(8), .FRAME_PIX(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .host_start(host_start), .host_ack(host_ack),
    .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_data(pix_data),
    .cnn_valid(cnn_valid), .cnn_pixel(cnn_pixel), .cnn_done(cnn_done),
    .cnn_alpha(cnn_alpha), .res_valid(res_valid), .res_alpha(res_alpha),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cnn_valid) fwd_q.push_back(cnn_pixel);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    host_start = 0; host_ack = 0; pix_sof = 0; pix_valid = 0;
    pix_data = '0; cnn_done = 0; cnn_alpha = '0;
  endtask

  task automatic pix(input logic sof, input logic [31:0] d);
    pix_valid = 1; pix_sof = sof; pix_data = d;
    tick();
    pix_valid = 0; pix_sof = 0; pix_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); tick(); reset = 0;
    tick();
    fwd_q.delete();
  endtask

  task automatic start();
    host_start = 1; tick(); host_start = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    pix_valid = 1; pix_sof = 1; pix_data = 32'hDEAD; host_start = 1; cnn_done = 1;
    tick(); tick();
    checks++;
    if ({cnn_valid, res_valid, busy, err_timeout} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {cnn_valid, res_valid, busy, err_timeout});
    end
    checks++;
    if (cnn_pixel !== 32'h0 || res_alpha !== 8'h0) begin
      failures++;
      $display("FAIL reset_data got pixel=%h alpha=%h want 0/0", cnn_pixel, res_alpha);
    end
    idle_inputs();
    reset = 0; tick();
    fwd_q.delete();
  endtask

  task automatic test_nominal();
    logic [31:0] exp_px[4];
    exp_px[0] = 32'h11; exp_px[1] = 32'h22; exp_px[2] = 32'h33; exp_px[3] = 32'h44;
    do_reset();
    start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL nom_busy_start got=%b want=1", busy); end
    pix(0, 32'hAAAA); pix(0, 32'hBBBB);
    pix(1, 32'h11); pix(0, 32'h22); pix(0, 32'h33); pix(0, 32'h44);
    pix(0, 32'h55);                      // arrives in WAIT_RES, must be dropped
    repeat (3) tick();
    cnn_done = 1; cnn_alpha = 8'h41; tick(); cnn_done = 0; cnn_alpha = 8'h00;
    checks++;
    if (fwd_q.size() !== 4) begin
      failures++; $display("FAIL nom_pix_count got=%0d want=4", fwd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fwd_q[i] !== exp_px[i]) begin
          failures++; $display("FAIL nom_pix%0d got=%h want=%h", i, fwd_q[i], exp_px[i]);
        end
      end
    end
    repeat (3) tick();
    checks++;
    if (res_valid !== 1'b1 || res_alpha !== 8'h41 || busy !== 1'b1) begin
      failures++;
      $display("FAIL nom_hold got valid=%b alpha=%h busy=%b want 1/41/1", res_valid, res_alpha, busy);
    end
    host_ack = 1; tick(); host_ack = 0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL nom_ack got valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start();
    pix(1, 32'h1); pix(0, 32'h2); pix(0, 32'h3); pix(0, 32'h4);
    repeat (15) tick();
    checks++;
    if (busy !== 1'b1 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL tmo_early got busy=%b err=%b want 1/0", busy, err_timeout);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL tmo_expire got busy=%b err=%b valid=%b want 0/1/0", busy, err_timeout, res_valid);
    end
    repeat (2) tick();
    checks++;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b want=1", err_timeout); end
    start();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL tmo_clear got err=%b busy=%b want 0/1", err_timeout, busy);
    end
  endtask

  task automatic test_short_frame();
    logic [31:0] exp_px[6];
    exp_px[0] = 32'hA1; exp_px[1] = 32'hA2; exp_px[2] = 32'hA3;
    exp_px[3] = 32'hB1; exp_px[4] = 32'hB2; exp_px[5] = 32'hB3;
    do_reset();
    start();
    pix(1, 32'hA1); pix(0, 32'hA2); pix(0, 32'hA3);
    pix(1, 32'hB0); pix(0, 32'hB1); pix(0, 32'hB2);
    cnn_done = 1; cnn_alpha = 8'h66; tick(); cnn_done = 0; cnn_alpha = 8'h00;
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL short_early_done got=%b want=0", res_valid); end
    pix(0, 32'hB3);
    cnn_done = 1; cnn_alpha = 8'h5A; tick(); cnn_done = 0; cnn_alpha = 8'h00;
    checks++;
    if (res_valid !== 1'b1 || res_alpha !== 8'h5A) begin
      failures++; $display("FAIL short_result got valid=%b alpha=%h want 1/5a", res_valid, res_alpha);
    end
    checks++;
    if (fwd_q.size() !== 6) begin
      failures++; $display("FAIL short_pix_count got=%0d want=6", fwd_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (fwd_q[i] !== exp_px[i]) begin
          failures++; $display("FAIL short_pix%0d got=%h want=%h", i, fwd_q[i], exp_px[i]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start();
    pix(1, 32'h1); pix(0, 32'h2); pix(0, 32'h3); pix(0, 32'h4);
    repeat (15) tick();
    cnn_done = 1; cnn_alpha = 8'h7E; tick(); cnn_done = 0; cnn_alpha = 8'h00;
    checks++;
    if (res_valid !== 1'b1 || res_alpha !== 8'h7E || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL sim_done_vs_tmo got valid=%b alpha=%h err=%b want 1/7e/0", res_valid, res_alpha, err_timeout);
    end
    fwd_q.delete();
    host_ack = 1; host_start = 1; tick(); host_ack = 0; host_start = 0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL sim_ack_start got valid=%b busy=%b want 0/1", res_valid, busy);
    end
    pix(0, 32'h98); pix(1, 32'h99);
    tick();
    checks++;
    if (fwd_q.size() !== 1 || fwd_q[0] !== 32'h99) begin
      failures++; $display("FAIL sim_wait_sof got n=%0d first=%h want 1/99", fwd_q.size(),
                           (fwd_q.size() > 0) ? fwd_q[0] : 32'h0);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    start();
    pix(1, 32'h1); pix(0, 32'h2);
    reset = 1; pix_valid = 1; pix_data = 32'h3;
    tick();
    checks++;
    if ({cnn_valid, res_valid, busy, err_timeout} !== 4'b0000 || cnn_pixel !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid got flags=%b pixel=%h want 0000/0", {cnn_valid, res_valid, busy, err_timeout}, cnn_pixel);
    end
    pix_data = 32'h4; tick();
    reset = 0;
    pix_data = 32'h5; tick(); pix_data = 32'h6; tick();
    pix_valid = 0; pix_data = '0;
    cnn_done = 1; cnn_alpha = 8'h33; tick(); cnn_done = 0; cnn_alpha = 8'h00;
    tick();
    checks++;
    if (fwd_q.size() !== 2 || res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_after got npix=%0d valid=%b busy=%b want 2/0/0", fwd_q.size(), res_valid, busy);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    cnn_done = 1; cnn_alpha = 8'h21; tick(); cnn_done = 0; cnn_alpha = 8'h00;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL ign_idle_done got valid=%b busy=%b want 0/0", res_valid, busy);
    end
    start();
    pix(1, 32'hC0);
    host_start = 1; pix(0, 32'hC1); host_start = 0;
    pix(0, 32'hC2); pix(0, 32'hC3);
    host_ack = 1; tick(); host_ack = 0;
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      failures++; $display("FAIL ign_ack_waitres got busy=%b valid=%b want 1/0", busy, res_valid);
    end
    cnn_done = 1; cnn_alpha = 8'h4C; tick(); cnn_done = 0; cnn_alpha = 8'h00;
    checks++;
    if (fwd_q.size() !== 4 || res_valid !== 1'b1 || res_alpha !== 8'h4C) begin
      failures++;
      $display("FAIL ign_start_stream got npix=%0d valid=%b alpha=%h want 4/1/4c", fwd_q.size(), res_valid, res_alpha);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_short_frame();
    test_simultaneous();
    test_reset_mid_stream();
    test_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
